// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio receive path.
package audio_pkg;

  localparam int unsigned AUD_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT
  } rx_state_t;

  typedef struct packed {
    logic [AUD_DATA_WIDTH-1:0] left;
    logic [AUD_DATA_WIDTH-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; head data comes straight from storage registers.
module sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sync.sv
// Multi-stage flop synchronizer for a single asynchronous input.
module sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S ADC deserializer: oversamples the codec's BCLK/LRCK/DATA and queues
// left/right sample pairs in a FWFT FIFO with a valid/ready handshake.
module audio_adc_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AUD_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clear_flags
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic w_bclk_s, w_lrck_s, w_dat_s;
  logic w_bclk_rise, w_lrck_edge;
  logic w_full, w_empty;
  logic [2*DATA_WIDTH-1:0] w_fifo_dout;

  rx_state_t             r_state;
  logic                  r_chan_right;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic                  r_push_req;
  logic                  r_bclk_d;
  logic                  r_lrck_prev;
  logic                  r_frame_err;
  logic                  r_overrun;

  sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .i_clk(Clk), .i_rst(Reset), .i_d(AUD_BCLK),    .o_q(w_bclk_s)
  );
  sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk(Clk), .i_rst(Reset), .i_d(AUD_ADCLRCK), .o_q(w_lrck_s)
  );
  sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .i_clk(Clk), .i_rst(Reset), .i_d(AUD_ADCDAT),  .o_q(w_dat_s)
  );

  assign w_bclk_rise = w_bclk_s & ~r_bclk_d;
  // LRCK is compared rise-to-rise so glitches between bit clocks are invisible.
  assign w_lrck_edge = w_bclk_rise & (w_lrck_s != r_lrck_prev);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_chan_right <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_push_req   <= 1'b0;
      r_bclk_d     <= 1'b0;
      r_lrck_prev  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_bclk_d   <= w_bclk_s;
      r_push_req <= 1'b0;
      if (w_bclk_rise) r_lrck_prev <= w_lrck_s;
      if (clear_flags) r_frame_err <= 1'b0;

      if (r_state != IDLE && !enable) begin
        r_state <= IDLE;
      end else if (w_bclk_rise) begin
        case (r_state)
          IDLE: begin
            if (enable && w_lrck_edge && !w_lrck_s) begin
              r_state      <= SKIP;
              r_chan_right <= 1'b0;
            end
          end
          SKIP: begin
            r_state <= SHIFT;
            r_cnt   <= '0;
          end
          SHIFT: begin
            if (w_lrck_edge) begin
              r_frame_err <= 1'b1;
              r_shift     <= '0;
              r_left_hold <= '0;
              if (!w_lrck_s) begin
                r_state      <= SKIP;
                r_chan_right <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_shift <= {r_shift[DATA_WIDTH-2:0], w_dat_s};
              r_cnt   <= r_cnt + CW'(1);
              if (r_cnt == LAST_BIT) begin
                if (!r_chan_right) r_left_hold <= {r_shift[DATA_WIDTH-2:0], w_dat_s};
                else               r_push_req  <= 1'b1;
                r_state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (w_lrck_edge) begin
              r_state      <= SKIP;
              r_chan_right <= ~r_chan_right;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_overrun <= 1'b0;
    end else begin
      if (clear_flags) r_overrun <= 1'b0;
      if (r_push_req && w_full && !sample_ready) r_overrun <= 1'b1;
    end
  end

  sample_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_push (r_push_req),
    .i_din  ({r_left_hold, r_shift}),
    .i_pop  (sample_ready),
    .o_dout (w_fifo_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign sample_valid = ~w_empty;
  assign left_out     = w_fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
  assign right_out    = w_fifo_dout[DATA_WIDTH-1:0];
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Bench for audio_adc_receiver: drives an I2S codec model and scoreboards pairs.
module tb_audio_adc_receiver;

  localparam int SYNC = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b1;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        dat = 1'b0;
  logic        ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic        sample_valid;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        overrun;
  logic        frame_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_exp;
  logic        check_lat = 1'b0;
  logic        pulse_rdy = 1'b0;

  audio_adc_receiver #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable),
    .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .sample_valid(sample_valid), .sample_ready(ready),
    .left_out(left_out), .right_out(right_out),
    .overrun(overrun), .frame_err(frame_err), .clear_flags(clear_flags)
  );

  always #10 Clk = ~Clk;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge Clk) begin
    if (!Reset && sample_valid && ready) begin
      n_vec++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pair_unexpected: got %h_%h, required no pair", left_out, right_out);
      end else begin
        m_exp = exp_q.pop_front();
        if ({left_out, right_out} !== m_exp) begin
          n_err++;
          $display("FAIL pair_data: got %h_%h, required %h_%h",
                   left_out, right_out, m_exp[31:16], m_exp[15:0]);
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One channel of nbits BCLK periods (16 Clk each); LRCK changes with rise 0.
  task automatic send_channel(input logic lr, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bclk = 1'b1;
      if (i == 0) lrck = lr;
      if (lr && i == 17 && (check_lat || pulse_rdy)) begin
        for (int j = 1; j <= 8; j++) begin
          @(posedge Clk); #1;
          if (pulse_rdy && j == SYNC + 1) ready = 1'b1;
          if (pulse_rdy && j == SYNC + 2) ready = 1'b0;
          if (check_lat && j == SYNC + 1) begin
            n_vec++;
            if (sample_valid !== 1'b0) begin
              n_err++;
              $display("FAIL latency_early: valid=%b, required 0", sample_valid);
            end
          end
          if (check_lat && j == SYNC + 2) begin
            n_vec++;
            if (sample_valid !== 1'b1) begin
              n_err++;
              $display("FAIL latency_on_time: valid=%b, required 1", sample_valid);
            end
          end
        end
      end else begin
        clk_wait(8);
      end
      bclk = 1'b0;
      dat  = (i + 1 >= 2 && i + 1 <= 17) ? w[17 - (i + 1)] : 1'b0;
      clk_wait(8);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit push_exp);
    send_channel(1'b0, l, 32);
    if (push_exp) exp_q.push_back({l, r});
    send_channel(1'b1, r, 32);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) clk_wait(1);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d pairs outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    clk_wait(1);
    clear_flags = 1'b0;
    clk_wait(1);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clk_wait(4);
    n_vec++;
    if (sample_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b, required 0", sample_valid);
    end
    n_vec++;
    if ({left_out, right_out} !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h_%h, required 0000_0000", left_out, right_out);
    end
    n_vec++;
    if ({overrun, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: got %b, required 00", {overrun, frame_err});
    end
    Reset = 1'b0;
    clk_wait(2);
    send_channel(1'b1, 16'h0000, 32);
  endtask

  task automatic test_basic();
    int unsigned p0;
    p0 = n_pops;
    ready = 1'b1;
    check_lat = 1'b1;
    send_frame(16'h8001, 16'h7FFE, 1'b1);
    check_lat = 1'b0;
    wait_drain();
    n_vec++;
    if (n_pops - p0 !== 1) begin
      n_err++; $display("FAIL basic_count: got %0d pairs, required 1", n_pops - p0);
    end
    n_vec++;
    if ({overrun, frame_err} !== 2'b00) begin
      n_err++; $display("FAIL basic_flags: got %b, required 00", {overrun, frame_err});
    end
  endtask

  task automatic test_start_align();
    int unsigned p0;
    Reset = 1'b1;
    send_channel(1'b0, 16'hDEAD, 32);
    send_channel(1'b1, 16'hBEEF, 8);
    Reset = 1'b0;
    send_channel(1'b1, 16'hBEEF, 24);
    p0 = n_pops;
    ready = 1'b1;
    send_frame(16'h0A01, 16'h0B01, 1'b1);
    send_frame(16'h0A02, 16'h0B02, 1'b1);
    send_frame(16'h0A03, 16'h0B03, 1'b1);
    wait_drain();
    n_vec++;
    if (n_pops - p0 !== 3) begin
      n_err++; $display("FAIL align_count: got %0d pairs, required 3", n_pops - p0);
    end
  endtask

  task automatic test_enable();
    int unsigned p0;
    p0 = n_pops;
    enable = 1'b0;
    send_frame(16'hAAAA, 16'h5555, 1'b0);
    enable = 1'b1;
    clk_wait(8);
    n_vec++;
    if (n_pops - p0 !== 0 || sample_valid !== 1'b0) begin
      n_err++; $display("FAIL enable_off: got %0d pairs valid=%b, required 0 pairs valid=0",
                        n_pops - p0, sample_valid);
    end
  endtask

  task automatic test_overrun();
    int unsigned p0;
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(16'(i), 16'(i), i <= 4);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    n_vec++;
    if (sample_valid !== 1'b1 || {left_out, right_out} !== 32'h0001_0001) begin
      n_err++; $display("FAIL overrun_head: got valid=%b %h_%h, required valid=1 0001_0001",
                        sample_valid, left_out, right_out);
    end
    p0 = n_pops;
    ready = 1'b1;
    wait_drain();
    clk_wait(4);
    n_vec++;
    if (n_pops - p0 !== 4 || sample_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_drain: got %0d pairs valid=%b, required 4 pairs valid=0",
                        n_pops - p0, sample_valid);
    end
    pulse_clear();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
  endtask

  task automatic test_full_pop();
    int unsigned p0;
    p0 = n_pops;
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b1);
    pulse_rdy = 1'b1;
    send_frame(16'h1005, 16'h2005, 1'b1);
    pulse_rdy = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL fullpop_overrun: got %b, required 0", overrun);
    end
    n_vec++;
    if (exp_q.size() !== 4) begin
      n_err++; $display("FAIL fullpop_occupancy: got %0d queued, required 4", exp_q.size());
    end
    ready = 1'b1;
    wait_drain();
    n_vec++;
    if (n_pops - p0 !== 5) begin
      n_err++; $display("FAIL fullpop_count: got %0d pairs, required 5", n_pops - p0);
    end
  endtask

  task automatic test_short_frame();
    int unsigned p0;
    p0 = n_pops;
    ready = 1'b1;
    send_channel(1'b0, 16'hCAFE, 32);
    send_channel(1'b1, 16'hBEEF, 10);
    send_frame(16'h1234, 16'h5678, 1'b1);
    wait_drain();
    n_vec++;
    if (frame_err !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL short_flags: got frame_err=%b overrun=%b, required 1 0",
                        frame_err, overrun);
    end
    n_vec++;
    if (n_pops - p0 !== 1) begin
      n_err++; $display("FAIL short_count: got %0d pairs, required 1", n_pops - p0);
    end
    pulse_clear();
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL short_clear: got %b, required 0", frame_err);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned p0;
    ready = 1'b0;
    send_frame(16'h00A1, 16'h00B1, 1'b1);
    send_frame(16'h00A2, 16'h00B2, 1'b1);
    send_channel(1'b0, 16'h4444, 12);
    n_vec++;
    if (sample_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: valid=%b, required 1", sample_valid);
    end
    Reset = 1'b1;
    #1;
    n_vec++;
    if ({sample_valid, left_out, right_out, overrun, frame_err} !== 35'h0) begin
      n_err++; $display("FAIL rstmid_outputs: got valid=%b %h_%h flags=%b, required all 0",
                        sample_valid, left_out, right_out, {overrun, frame_err});
    end
    exp_q.delete();
    clk_wait(3);
    Reset = 1'b0;
    p0 = n_pops;
    ready = 1'b1;
    send_channel(1'b0, 16'h4444, 20);
    send_channel(1'b1, 16'h5555, 32);
    send_frame(16'h2222, 16'h3333, 1'b1);
    wait_drain();
    n_vec++;
    if (n_pops - p0 !== 1) begin
      n_err++; $display("FAIL rstmid_resume: got %0d pairs, required 1", n_pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_align();
    test_enable();
    test_overrun();
    test_full_pop();
    test_short_frame();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
